// File: rtl/jkbank_arbiter.sv
// jkbank_arbiter: round-robin arbiter sharing one jkff bank via registered J/K vectors.
// Define ARB_LOCK_EN to enable per-owner burst locking (LOCKED state, burst counter).
module jkbank_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int IDW       = 2,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [2*N-1:0]     op,
  input  logic [N*WIDTH-1:0] data,
  input  logic [N-1:0]       lock,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   j,
  output logic [WIDTH-1:0]   k,
  output logic               busy,
  output logic [IDW-1:0]     owner
);

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_e;
  logic [CW-1:0] cnt_q;
`else
  localparam int unused_mb = MAX_BURST;
  typedef enum logic {IDLE, GRANT} state_e;
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  state_e           state_q;
  logic [N-1:0]     gnt_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic [IDW-1:0]   owner_q;
  logic [IDW-1:0]   ptr_q;

  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  int               c;
  logic             hold;
  logic             sel_vld;
  logic [IDW-1:0]   sel_idx;
  logic [IDW-1:0]   nxt_ptr;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_m;
  logic [WIDTH-1:0] jk_j;
  logic [WIDTH-1:0] jk_k;

  // First requester at or after the pointer, wrapping modulo N
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    c       = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr_q) + i;
      if (c >= N) c = c - N;
      if (!win_vld && req[c]) begin
        win_vld = 1'b1;
        win_idx = IDW'(c);
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign hold = (state_q == LOCKED) && req[owner_q]
             && lock[owner_q] && (cnt_q < CW'(MAX_BURST));
`else
  assign hold = 1'b0;
`endif

  assign sel_vld = hold | win_vld;
  assign sel_idx = hold ? owner_q : win_idx;
  assign nxt_ptr = (sel_idx == IDW'(N - 1)) ? '0 : sel_idx + 1'b1;
  assign sel_op  = op[2*sel_idx +: 2];
  assign sel_m   = data[WIDTH*sel_idx +: WIDTH];

  // LOAD is the D-flop conversion J=d, K=~d
  always_comb begin
    jk_j = '0;
    jk_k = '0;
    unique case (sel_op)
      2'b00: begin jk_j = sel_m; jk_k = ~sel_m; end
      2'b01: jk_j = sel_m;
      2'b10: jk_k = sel_m;
      2'b11: begin jk_j = sel_m; jk_k = sel_m; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else if (sel_vld) begin
      gnt_q   <= N'(1) << sel_idx;
      j_q     <= jk_j;
      k_q     <= jk_k;
      owner_q <= sel_idx;
      ptr_q   <= nxt_ptr;
`ifdef ARB_LOCK_EN
      if (hold) begin
        state_q <= LOCKED;
        cnt_q   <= cnt_q + 1'b1;
      end else if (lock[sel_idx]) begin
        state_q <= LOCKED;
        cnt_q   <= CW'(1);
      end else begin
        state_q <= GRANT;
        cnt_q   <= '0;
      end
`else
      state_q <= GRANT;
`endif
    end else begin
      state_q <= IDLE;
      gnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
`ifdef ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign j     = j_q;
  assign k     = k_q;
  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_jkbank_arbiter.sv
// tb_jkbank_arbiter: directed and randomized checks of jkbank_arbiter
// against a round-robin reference model.
module tb_jkbank_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] op = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   lock = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   j;
  logic [W-1:0]   k;
  logic           busy;
  logic [1:0]     owner;

  int pass_cnt = 0;
  int total    = 0;
  int m_ptr    = 0;
  int m_owner  = 0;
  logic [22:0] exp;
  wire  [22:0] obs = {gnt, j, k, busy, owner};

  always #5 clk = ~clk;

  jkbank_arbiter #(.N(N), .WIDTH(W), .IDW(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .data(data), .lock(lock),
    .gnt(gnt), .j(j), .k(k), .busy(busy), .owner(owner)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = '0; lock = '0; op = '0; data = '0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    m_ptr = 0;
    m_owner = 0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #1;
    exp = '0;
    total++;
    if (obs !== exp) $display("FAIL reset_init: got %h want %h", obs, exp);
    else pass_cnt++;
    rst = 1'b1;
    req = 4'b0010;
    tick;
    exp = {4'b0010, 8'h00, 8'hFF, 1'b1, 2'd1};
    total++;
    if (obs !== exp) $display("FAIL pre_reset_grant: got %h want %h", obs, exp);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    exp = '0;
    total++;
    if (obs !== exp) $display("FAIL reset_async: got %h want %h", obs, exp);
    else pass_cnt++;
    req = '0;
    #1 rst = 1'b1;
  endtask

  task automatic test_load;
    req = 4'b0100;
    op[5:4] = 2'b00;
    data[23:16] = 8'hA5;
    tick;
    exp = {4'b0100, 8'hA5, 8'h5A, 1'b1, 2'd2};
    total++;
    if (obs !== exp) $display("FAIL load: got %h want %h", obs, exp);
    else pass_cnt++;
    req = '0;
    tick;
    exp = {4'b0000, 8'h00, 8'h00, 1'b0, 2'd2};
    total++;
    if (obs !== exp) $display("FAIL idle_hold_owner: got %h want %h", obs, exp);
    else pass_cnt++;
    data = '0;
  endtask

  task automatic test_ops;
    logic [1:0] ops [3];
    logic [W-1:0] ej [3];
    logic [W-1:0] ek [3];
    logic [W-1:0] eq [3];
    logic [W-1:0] q;
    ops = '{2'b01, 2'b10, 2'b11};
    ej  = '{8'h0F, 8'h00, 8'h0F};
    ek  = '{8'h00, 8'h0F, 8'h0F};
    eq  = '{8'h0F, 8'h00, 8'h0F};
    q = 8'h00;
    req = 4'b0001;
    data[7:0] = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      op[1:0] = ops[i];
      tick;
      exp = {4'b0001, ej[i], ek[i], 1'b1, 2'd0};
      total++;
      if (obs !== exp) $display("FAIL op%0d_jk: got %h want %h", i, obs, exp);
      else pass_cnt++;
      q = (j & ~q) | (~k & q);
      total++;
      if (q !== eq[i]) $display("FAIL op%0d_bank: got %h want %h", i, q, eq[i]);
      else pass_cnt++;
    end
    req = '0; op = '0; data = '0;
    tick;
  endtask

  task automatic test_fairness;
    do_reset;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick;
      exp = {4'(1 << (i % 4)), 8'h00, 8'hFF, 1'b1, 2'(i % 4)};
      total++;
      if (obs !== exp) $display("FAIL fair%0d: got %h want %h", i, obs, exp);
      else pass_cnt++;
    end
    req = '0;
    tick;
  endtask

  task automatic test_wrap;
    req = 4'b0100;
    tick;
    req = '0;
    tick;
    req = 4'b1001;
    tick;
    exp = {4'b1000, 8'h00, 8'hFF, 1'b1, 2'd3};
    total++;
    if (obs !== exp) $display("FAIL wrap_3: got %h want %h", obs, exp);
    else pass_cnt++;
    tick;
    exp = {4'b0001, 8'h00, 8'hFF, 1'b1, 2'd0};
    total++;
    if (obs !== exp) $display("FAIL wrap_0: got %h want %h", obs, exp);
    else pass_cnt++;
    req = 4'b1111;
    tick;
    exp = {4'b0010, 8'h00, 8'hFF, 1'b1, 2'd1};
    total++;
    if (obs !== exp) $display("FAIL wrap_ptr1: got %h want %h", obs, exp);
    else pass_cnt++;
    req = '0;
    tick;
  endtask

  task automatic test_lock;
    logic [N-1:0] eg [5];
`ifdef ARB_LOCK_EN
    eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
`else
    eg = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
    do_reset;
    req = 4'b0001;
    tick;
    req = 4'b0011;
    lock = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (gnt !== eg[i]) $display("FAIL lock%0d: got %b want %b", i, gnt, eg[i]);
      else pass_cnt++;
    end
    req = '0; lock = '0;
    tick;
  endtask

  task automatic test_random;
    logic [N-1:0] e_gnt;
    logic [W-1:0] e_j;
    logic [W-1:0] e_k;
    logic         e_busy;
    logic [W-1:0] m;
    logic [1:0]   o;
    int           ci;
    do_reset;
    for (int t = 0; t < 300; t++) begin
      req  = 4'($urandom_range(0, 15));
      op   = 8'($urandom());
      data = 32'($urandom());
      e_gnt = '0; e_j = '0; e_k = '0; e_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        ci = (m_ptr + i) % N;
        if (req[ci]) begin
          m = data[ci*W +: W];
          o = op[2*ci +: 2];
          e_gnt[ci] = 1'b1;
          e_busy = 1'b1;
          case (o)
            2'd0: begin e_j = m; e_k = ~m; end
            2'd1: e_j = m;
            2'd2: e_k = m;
            default: begin e_j = m; e_k = m; end
          endcase
          m_owner = ci;
          m_ptr = (ci + 1) % N;
          break;
        end
      end
      exp = {e_gnt, e_j, e_k, e_busy, 2'(m_owner)};
      tick;
      total++;
      if (obs !== exp) $display("FAIL rand%0d: got %h want %h", t, obs, exp);
      else pass_cnt++;
    end
    req = '0; op = '0; data = '0;
    tick;
  endtask

  initial begin
    test_reset;
    test_load;
    test_ops;
    test_fairness;
    test_wrap;
    test_lock;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
